// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage and control unit:
// fetch FSM encoding, reset PC default and opcode field layout/constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SKID  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: reset load, +4 increment (32-bit wrap) and redirect load
// with the low two bits forced to zero. Redirect wins over increment.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  input  logic        i_load,
  input  logic [31:2] i_load_pc,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= {RESET_PC[31:2], 2'b00};
    end else if (i_load) begin
      r_pc <= {i_load_pc, 2'b00};
    end else if (i_inc) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: handshakes with instruction memory, buffers one
// extra word in a skid register under stall, and flushes on redirect.
module busca_instrucao
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [31:0]         pc_out,
  output logic [31:0]         pc_plus4
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic [31:0] w_pc;
  logic        w_pc_inc;
  logic        w_req;
  logic        w_consume;
  logic        w_out_from_mem;
  logic        w_out_from_skid;
  logic        w_to_skid;
  logic        w_drain_capture;
  logic [1:0]  w_unused_rpc_bits;

  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_drain_addr;

  assign w_unused_rpc_bits = redirect_pc[1:0];
  assign w_consume         = r_instr_valid & ~stall;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_pc_inc),
    .i_load   (redirect),
    .i_load_pc(redirect_pc[31:2]),
    .o_pc     (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_req           = 1'b0;
    w_pc_inc        = 1'b0;
    w_out_from_mem  = 1'b0;
    w_out_from_skid = 1'b0;
    w_to_skid       = 1'b0;
    w_drain_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_REQ;
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (redirect) begin
          // Without an ack the old request is still in flight and must be drained.
          if (!imem_ack) begin
            w_state_next    = ST_DRAIN;
            w_drain_capture = 1'b1;
          end
        end else if (imem_ack) begin
          w_pc_inc = 1'b1;
          if (!r_instr_valid || w_consume) begin
            w_out_from_mem = 1'b1;
          end else begin
            w_to_skid    = 1'b1;
            w_state_next = ST_SKID;
          end
        end
      end
      ST_SKID: begin
        if (redirect) begin
          w_state_next = ST_REQ;
        end else if (w_consume) begin
          w_out_from_skid = 1'b1;
          w_state_next    = ST_REQ;
        end
      end
      ST_DRAIN: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_state_next = ST_REQ;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0000_0000;
      r_pc_out      <= RESET_PC;
      r_skid_instr  <= 32'h0000_0000;
      r_skid_pc     <= 32'h0000_0000;
      r_drain_addr  <= 32'h0000_0000;
    end else begin
      if (w_out_from_mem) begin
        r_instr  <= imem_rdata;
        r_pc_out <= w_pc;
      end else if (w_out_from_skid) begin
        r_instr  <= r_skid_instr;
        r_pc_out <= r_skid_pc;
      end
      if (w_to_skid) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= w_pc;
      end
      if (w_drain_capture) begin
        r_drain_addr <= w_pc;
      end
      if (redirect) begin
        r_instr_valid <= 1'b0;
      end else if (w_out_from_mem || w_out_from_skid) begin
        r_instr_valid <= 1'b1;
      end else if (w_consume) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = (r_state == ST_DRAIN) ? r_drain_addr : w_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign opcode      = get_opcode(r_instr);
  assign pc_out      = r_pc_out;
  assign pc_plus4    = r_pc_out + 32'd4;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: latency-programmable memory model,
// scoreboard of consumed instructions, and a wrap-around second instance.
module tb_busca_instrucao;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr, pc_out, pc_plus4;
  logic [5:0]  opcode;

  logic        imem_req2, imem_ack2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        stall2, redirect2;
  logic [31:0] redirect_pc2;
  logic        instr_valid2;
  logic [31:0] instr2, pc_out2, pc_plus42;
  logic [5:0]  opcode2;

  busca_instrucao dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .pc_out(pc_out), .pc_plus4(pc_plus4)
  );

  busca_instrucao #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .instr_valid(instr_valid2), .instr(instr2), .opcode(opcode2),
    .pc_out(pc_out2), .pc_plus4(pc_plus42)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h8C01_0004;
    if (a == 32'h0000_0004) return 32'h0022_1820;
    return {8'hA5, a[23:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] word);
    exp_pc_q.push_back(pc);
    exp_instr_q.push_back(word);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Memory for dut: once a request is seen it answers after lat cycles,
  // even if the requester has been reset in the meantime.
  int          lat = 0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = memw(paddr);
          pend       = 1'b0;
        end else begin
          cnt--;
        end
      end else if (imem_req === 1'b1) begin
        if (lat == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = memw(imem_addr);
        end else begin
          pend  = 1'b1;
          paddr = imem_addr;
          cnt   = lat - 1;
        end
      end
    end
  end

  initial begin
    imem_ack2   = 1'b0;
    imem_rdata2 = 32'h0;
    forever begin
      @(negedge clk);
      imem_ack2   = (imem_req2 === 1'b1);
      imem_rdata2 = memw(imem_addr2);
    end
  end

  initial begin
    logic [31:0] epc, ei;
    forever begin
      @(negedge clk);
      #3;
      if (instr_valid === 1'b1 && stall === 1'b0) begin
        if (exp_pc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_consume actual pc=%h instr=%h required=none", pc_out, instr);
        end else begin
          epc = exp_pc_q.pop_front();
          ei  = exp_instr_q.pop_front();
          $display("consume pc=%h instr=%h expect pc=%h instr=%h", pc_out, instr, epc, ei);
          chk("consume_pc", pc_out, epc);
          chk("consume_instr", instr, ei);
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    stall        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    stall2       = 1'b0;
    redirect2    = 1'b0;
    redirect_pc2 = 32'h0;

    push_exp(32'h0000_0000, 32'h8C01_0004);
    push_exp(32'h0000_0004, 32'h0022_1820);
    push_exp(32'h0000_0008, 32'hA500_0008);
    push_exp(32'h0000_000C, 32'hA500_000C);

    step();
    step();
    // cycle 1: reset state, reset released in this cycle
    step();
    chk("reset_req", imem_req, 32'd0);
    chk("reset_valid", instr_valid, 32'd0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_pc_out", pc_out, 32'h0);
    chk("reset_pc_out2", pc_out2, 32'hFFFF_FFF8);
    reset = 1'b0;
    // cycle 2: first request
    step();
    chk("first_req", imem_req, 32'd1);
    chk("addr_c2", imem_addr, 32'h0);
    chk("addr2_c2", imem_addr2, 32'hFFFF_FFF8);
    // cycle 3
    step();
    chk("valid_c3", instr_valid, 32'd1);
    chk("opcode_lw", opcode, 32'h23);
    chk("addr_c3", imem_addr, 32'h4);
    chk("pc_plus4_c3", pc_plus4, 32'h4);
    chk("addr2_c3", imem_addr2, 32'hFFFF_FFFC);
    // cycle 4
    step();
    chk("opcode_rtype", opcode, 32'h0);
    chk("addr_c4", imem_addr, 32'h8);
    chk("addr2_wrap", imem_addr2, 32'h0);
    chk("pc_plus4_2_wrap", pc_plus42, 32'h0);
    lat = 1;
    // cycle 5: stall begins with the request for 0xC outstanding
    step();
    chk("pc_out_c5", pc_out, 32'h8);
    chk("pc_out2_c5", pc_out2, 32'h0);
    chk("pc_plus4_2_c5", pc_plus42, 32'h4);
    stall = 1'b1;
    // cycle 6: ack arrives while output is occupied
    step();
    chk("req_c6", imem_req, 32'd1);
    chk("addr_c6", imem_addr, 32'hC);
    // cycle 7: skid holding, request dropped
    step();
    chk("skid_req", imem_req, 32'd0);
    chk("skid_instr_held", instr, 32'hA500_0008);
    chk("skid_valid", instr_valid, 32'd1);
    // cycle 8: release stall
    step();
    chk("skid_req_c8", imem_req, 32'd0);
    chk("skid_pc_held", pc_out, 32'h8);
    stall = 1'b0;
    // cycle 9: skid entry presented
    step();
    chk("skid_out_pc", pc_out, 32'hC);
    chk("addr_c9", imem_addr, 32'h10);
    lat = 2;
    // cycle 10
    step();
    chk("valid_c10", instr_valid, 32'd0);
    // cycle 11: redirect with request outstanding; held instruction is flushed
    step();
    chk("pc_out_c11", pc_out, 32'h10);
    chk("addr_c11", imem_addr, 32'h14);
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    // cycle 12: draining old request
    step();
    chk("flush_valid", instr_valid, 32'd0);
    chk("drain_req", imem_req, 32'd1);
    chk("drain_addr", imem_addr, 32'h14);
    redirect = 1'b0;
    stall    = 1'b0;
    push_exp(32'h0000_0040, 32'hA500_0040);
    push_exp(32'h0000_0044, 32'hA500_0044);
    // cycle 13: late data arrives and is discarded
    step();
    chk("drain_addr_c13", imem_addr, 32'h14);
    // cycle 14
    step();
    chk("redirect_addr", imem_addr, 32'h40);
    chk("valid_c14", instr_valid, 32'd0);
    lat = 0;
    step();
    step();
    chk("valid_c16", instr_valid, 32'd0);
    // cycle 17
    step();
    chk("pc_out_c17", pc_out, 32'h40);
    lat = 2;
    // cycle 18
    step();
    chk("pc_out_c18", pc_out, 32'h44);
    // cycle 19: reset during an outstanding request
    step();
    chk("addr_c19", imem_addr, 32'h48);
    reset = 1'b1;
    // cycle 20: late ack lands here and must be ignored
    step();
    chk("rst2_req", imem_req, 32'd0);
    chk("rst2_valid", instr_valid, 32'd0);
    chk("rst2_instr", instr, 32'h0);
    chk("rst2_pc_out", pc_out, 32'h0);
    reset = 1'b0;
    lat   = 0;
    push_exp(32'h0000_0000, 32'h8C01_0004);
    // cycle 21
    step();
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_valid_c21", instr_valid, 32'd0);
    chk("rst2_nop", instr, 32'h0);
    // cycle 22
    step();
    chk("rst2_first_valid", instr_valid, 32'd1);
    chk("rst2_first_pc", pc_out, 32'h0);
    // cycle 23: freeze consumption
    step();
    stall = 1'b1;
    repeat (5) step();
    checks++;
    if (exp_pc_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_pc_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
